// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// Handshake: start is a request that is taken only on an edge where busy is low.
// There is no ready signal. Operands are captured on that edge. done pulses for
// one cycle when sum/cout/ovf update.
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop, LSB first.
// Produces {cout,sum} = a+b+cin plus signed overflow, with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_if.slave      bus,
  output logic [0:0]         fsm_state
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             bit_s;
  logic             carry_nxt;

  assign bit_s     = a_sr[0] ^ b_sr[0] ^ c;
  assign carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      s_sr     <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            c        <= bus.cin;
            s_sr     <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          s_sr <= {bit_s, s_sr[WIDTH-1:1]};
          c    <= carry_nxt;
          cnt  <= cnt + CW'(1);
          // On the MSB, c still holds the carry into the MSB.
          if (cnt == CW'(WIDTH - 1)) begin
            bus.sum  <= {bit_s, s_sr[WIDTH-1:1]};
            bus.cout <= carry_nxt;
            bus.ovf  <= c ^ carry_nxt;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed corner cases, timing,
// abort and back-to-back scenarios, plus a random regression against a+b+cin.
module tb_serial_adder;
  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [0:0] fsm_state;
  int         checks;
  int         errors;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: plain arithmetic on the operands
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [W:0] full;
    logic       ov;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ov   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ov, full};
  endfunction

  // driver: issue one operation from IDLE and wait for done
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.cin   = 1'($urandom);
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
  endtask

  task automatic check_result(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic cin);
    logic [W+1:0] exp;
    int lat;
    exp = model(a, b, cin);
    run_op(a, b, cin, lat);
    checks++;
    if (bus.done !== 1'b1 || lat != W) begin
      errors++;
      $display("FAIL %s latency: got %0d done=%b, expected %0d", name, lat, bus.done, W);
    end
    checks++;
    if ({bus.ovf, bus.cout, bus.sum} !== exp) begin
      errors++;
      $display("FAIL %s result: got ovf=%b cout=%b sum=%h, expected ovf=%b cout=%b sum=%h",
               name, bus.ovf, bus.cout, bus.sum, exp[W+1], exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf, fsm_state} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b state=%b, expected all 0",
                 bus.busy, bus.done, bus.sum, bus.cout, bus.ovf, fsm_state);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int busy_cycles;
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h3C; bus.b = 8'h0F; bus.cin = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy_cycles = 0;
    lat = 0;
    while (lat < 50 && !bus.done) begin
      if (bus.busy) busy_cycles++;
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (busy_cycles != W) begin
      errors++;
      $display("FAIL basic_busy: got %0d busy cycles, expected %0d", busy_cycles, W);
    end
    checks++;
    if (lat != W || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: got %0d busy=%b, expected %0d busy=0", lat, bus.busy, W);
    end
    checks++;
    if ({bus.ovf, bus.cout, bus.sum} !== {1'b0, 1'b0, 8'h4B}) begin
      errors++;
      $display("FAIL basic_result: got ovf=%b cout=%b sum=%h, expected 0 0 4b",
               bus.ovf, bus.cout, bus.sum);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got done=%b one cycle later, expected 0", bus.done);
    end
  endtask

  task automatic test_corners;
    check_result("ff_plus_01", 8'hFF, 8'h01, 1'b0);
    check_result("7f_plus_01", 8'h7F, 8'h01, 1'b0);
    check_result("80_plus_80", 8'h80, 8'h80, 1'b0);
    check_result("ff_plus_cin", 8'hFF, 8'h00, 1'b1);
    check_result("zero_plus_cin", 8'h00, 8'h00, 1'b1);
  endtask

  task automatic test_ignored_start;
    logic [W-1:0] prev_sum;
    int dones;
    int cyc;
    prev_sum = bus.sum;
    dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      #1;
      bus.start = (cyc == 3 || cyc == 5);
      if (bus.start) begin
        bus.a = 8'hAA; bus.b = 8'h55;
      end
      if (bus.done) begin
        dones++;
        checks++;
        if (bus.sum !== 8'h30 || cyc != W) begin
          errors++;
          $display("FAIL ignored_start_result: got sum=%h at cycle %0d, expected 30 at %0d",
                   bus.sum, cyc, W);
        end
      end else if (cyc < W) begin
        checks++;
        if (bus.sum !== prev_sum) begin
          errors++;
          $display("FAIL sum_hold: got %h at cycle %0d, expected %h", bus.sum, cyc, prev_sum);
        end
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignored_start_done_count: got %0d, expected 1", dones);
    end
  endtask

  task automatic test_reset_abort;
    int dones;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf, fsm_state} !== '0) begin
      errors++;
      $display("FAIL abort_clear: got busy=%b done=%b sum=%h cout=%b ovf=%b state=%b, expected all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.ovf, fsm_state);
    end
    dones = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses, expected 0", dones);
    end
    check_result("after_abort", 8'h01, 8'h02, 1'b0);
  endtask

  task automatic test_back_to_back;
    int last;
    int seen;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h05; bus.b = 8'h03; bus.cin = 1'b0;
    last = -1;
    seen = 0;
    for (int cyc = 0; cyc < 100 && seen < 4; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen++;
        checks++;
        if (bus.sum !== 8'h08) begin
          errors++;
          $display("FAIL b2b_sum: got %h, expected 08", bus.sum);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != W + 1) begin
            errors++;
            $display("FAIL b2b_interval: got %0d, expected %0d", cyc - last, W + 1);
          end
        end
        last = cyc;
      end
    end
    checks++;
    if (seen != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d done pulses, expected 4", seen);
    end
    bus.start = 1'b0;
    // let any in-flight operation finish before the next scenario
    repeat (W + 2) @(posedge clk);
  endtask

  task automatic test_random;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W+1:0] exp;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      a   = W'($urandom_range(0, (1 << W) - 1));
      b   = W'($urandom_range(0, (1 << W) - 1));
      cin = 1'($urandom_range(0, 1));
      exp = model(a, b, cin);
      run_op(a, b, cin, lat);
      checks++;
      if (lat != W || {bus.ovf, bus.cout, bus.sum} !== exp) begin
        errors++;
        $display("FAIL random[%0d] %h+%h+%b: got lat=%0d ovf=%b cout=%b sum=%h, expected lat=%0d ovf=%b cout=%b sum=%h",
                 i, a, b, cin, lat, bus.ovf, bus.cout, bus.sum, W, exp[W+1], exp[W], exp[W-1:0]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_corners();
    test_ignored_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
